mem_sram_ctrl: RTL
==================

# mem_sram_ctrl

Memory-stage controller placed directly downstream of the EXE/MEM pipeline register. It turns one 32-bit load or store from the pipeline into two 16-bit accesses on the board's external SRAM. While an access is in flight it drives `ready` low, which freezes every pipeline register. Load data is registered on `rdata` for the MEM/WB register.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: extra idle cycles after the two half-word accesses (SRAM recovery). Legal range 0..15.
- `DATA_BASE`, default 1024: byte address mapped to SRAM half-word address 0.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `mem_r_en`  in  1  load request from the EXE/MEM register.
- `mem_w_en`  in  1  store request; takes priority over `mem_r_en` when both are high.
- `addr`  in  32  byte address (ALU result).
- `wdata`  in  32  store data (Rm value).
- `rdata`  out  32  registered load data. Holds its value until the next load completes.
- `ready`  out  1  combinational. 0 means freeze the pipeline.
- `sram_addr`  out  18  SRAM half-word address.
- `sram_we_n`  out  1  SRAM write strobe, active-low.
- `sram_dq_out`  out  16  write data to the pad.
- `sram_dq_oe`  out  1  1 means the pad drives `sram_dq_out`.
- `sram_dq_in`  in  16  read data from the pad. Treated as valid within the same cycle the address is presented.

## Operation
- Word index: `w = (addr - DATA_BASE) >> 2`, computed modulo 2^32 and truncated to 17 bits.
  - No range check. Addresses below `DATA_BASE` wrap.
  - `addr[1:0]` is ignored.
- Half-word addresses:
  - low half → `{w,1'b0}`
  - high half → `{w,1'b1}`
- Little-endian: low half-word = `data[15:0]`.
- States:
  - IDLE
    - Request (`mem_r_en|mem_w_en`) → LO.
    - Otherwise stay in IDLE.
  - LO: present the low half-word address.
    - Write: `sram_we_n=0`, `sram_dq_oe=1`, `sram_dq_out=wdata[15:0]`.
    - Read: capture `sram_dq_in` into a 16-bit holding register.
    - → HI.
  - HI: present the high half-word address.
    - Write: drive `wdata[31:16]` with `we_n=0`.
    - Read: `rdata <= {sram_dq_in, hold}` at the end of this cycle.
    - → WAIT if `WAIT_CYCLES>0`, else → DONE.
  - WAIT: a 4-bit counter counts `WAIT_CYCLES` cycles; then → DONE.
  - DONE: `ready=1` for exactly one cycle; → IDLE unconditionally.
- The operation type (read/write) is latched at the IDLE→LO transition.
  - `addr` and `wdata` are used live. They stay stable because the pipeline is frozen.
  - Request changes after IDLE do not alter the operation in flight.
- `ready`:
  - IDLE: `ready = ~(mem_r_en|mem_w_en)`.
  - LO, HI, WAIT: 0.
  - DONE: 1.
- Outside write LO/HI: `sram_we_n=1`, `sram_dq_oe=0`, `sram_dq_out=0`.
  - `sram_addr` = 0 in IDLE, WAIT and DONE.

## Timing
- Reset values: state IDLE, `rdata=0`, `sram_we_n=1`, `sram_dq_oe=0`, `sram_addr=0`, `sram_dq_out=0`, wait counter 0.
  - `ready` follows the IDLE rule immediately after reset.
- Request seen in IDLE at cycle 0:
  - LO at cycle 1, HI at cycle 2.
  - WAIT at cycles 3..2+`WAIT_CYCLES`.
  - DONE at cycle 3+`WAIT_CYCLES`.
  - With the default, `ready` is low for 5 cycles and high in the 6th.
- Load data is visible on `rdata` from the first cycle of WAIT (or of DONE) onward. It is stable by the DONE edge, where MEM/WB captures it.
- The DONE cycle never restarts the still-present old request. A new request is evaluated only in the IDLE cycle that follows.
- Back-to-back accesses: each access costs 4+`WAIT_CYCLES` cycles, including one IDLE cycle.
- `rst` during LO/HI: the write strobe is released asynchronously at once. The SRAM word may be half-written; this is accepted.
- `rst` mid-read leaves `rdata=0`.
- No request: the block stays in IDLE with `ready=1` and all outputs at idle values.

## Test plan
- Reset: assert `rst` mid-write-LO → same cycle `sram_we_n=1`, `sram_dq_oe=0`. After release with no request: `ready=1`, `rdata=0`.
- Store: `addr=1024`, `wdata=0xDEADBEEF`, `mem_w_en=1`.
  - Cycle 1: `sram_addr=0`, dq `0xBEEF`, `we_n=0`.
  - Cycle 2: `sram_addr=1`, dq `0xDEAD`.
  - `ready` low in cycles 0..4, high in cycle 5.
- Load back: `addr=1024`, `mem_r_en=1` with an SRAM model holding the stored word → `rdata=0xDEADBEEF` by the DONE cycle. `we_n` stays high throughout.
- Both enables high: `addr=1032`, `wdata=0x12345678` → a write is performed at half-words 4 and 5, and `rdata` is unchanged.
- Back-to-back loads from 1028 then 1036, with the request held after DONE → the second access's LO starts exactly 2 cycles after the first DONE, and addresses are 2/3 then 6/7.
- `WAIT_CYCLES=0` build: the access shows `ready` low for 3 cycles and high on the 4th. Also `addr=1020` wraps to word index 0x1FFFF, giving `sram_addr` 0x3FFFE and 0x3FFFF.

Source files
------------

// File: rtl/mem_sram_ctrl.sv
// Memory-stage SRAM controller: one 32-bit load/store becomes two
// 16-bit SRAM accesses, with the pipeline frozen via ready.
module mem_sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DATA_BASE   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic        sram_we_n,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] WLAST =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [31:0] BASE = 32'(DATA_BASE);

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] hold_q, hold_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req;
  logic [31:0] off;
  logic [16:0] widx;

  assign req  = mem_r_en | mem_w_en;
  assign off  = addr - BASE;
  assign widx = off[18:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      cnt_q   <= 4'd0;
      hold_q  <= 16'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_LO;
          wr_d    = mem_w_en;
        end
      end
      S_LO: begin
        if (!wr_q) hold_d = sram_dq_in;
        state_d = S_HI;
      end
      S_HI: begin
        if (!wr_q) rdata_d = {sram_dq_in, hold_q};
        cnt_d   = 4'd0;
        state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
      end
      S_WAIT: begin
        if (cnt_q == WLAST) begin
          cnt_d   = 4'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pad outputs decode the registered state only, so an async reset
  // releases the write strobe in the same instant.
  always_comb begin
    ready       = 1'b0;
    sram_addr   = 18'd0;
    sram_we_n   = 1'b1;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    unique case (state_q)
      S_IDLE: ready = ~req;
      S_LO: begin
        sram_addr = {widx, 1'b0};
        if (wr_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata[15:0];
        end
      end
      S_HI: begin
        sram_addr = {widx, 1'b1};
        if (wr_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata[31:16];
        end
      end
      S_WAIT: ready = 1'b0;
      S_DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign rdata = rdata_q;

endmodule
